// File: rtl/program_memory_sync_pkg.sv
// Shared types and power-up program image for the synchronous program memory.
package program_memory_sync_pkg;

   typedef logic [15:0] instr_t;

   typedef enum logic {
      PM_IDLE = 1'b0,
      PM_LOAD = 1'b1
   } pm_state_e;

   // Boot image: word0 and word1; every other word powers up as zero.
   localparam instr_t [1:0] DEFAULT_PROGRAM = {16'hB305, 16'hB203};

endpackage

// File: rtl/program_memory_sync_if.sv
// Fetch request/response channels plus the bootloader LOAD port of the program memory.
interface program_memory_sync_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   // Handshake: a beat transfers on a rising edge where valid & ready are both 1. A source
   // holds valid and its payload stable until the transfer; ready may depend on valid.
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_instr;
   logic                  rsp_ready;
   logic                  load_start;
   logic                  load_valid;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_done;
   logic                  loading;
   logic [ADDR_WIDTH:0]   load_count;

   modport master (
      output req_valid, req_addr, rsp_ready,
      output load_start, load_valid, load_addr, load_data, load_done,
      input  req_ready, rsp_valid, rsp_instr, loading, load_count
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      input  load_start, load_valid, load_addr, load_data, load_done,
      output req_ready, rsp_valid, rsp_instr, loading, load_count
   );

endinterface

// File: rtl/program_memory_sync_storage.sv
// 1R1W synchronous word array with a registered read port; contents survive reset.
module program_memory_sync_storage
   import program_memory_sync_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
      0:       DATA_WIDTH'(DEFAULT_PROGRAM[0]),
      1:       DATA_WIDTH'(DEFAULT_PROGRAM[1]),
      default: '0
   };

   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register only updates on an accepted read, so a stalled response stays stable.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/program_memory_sync.sv
// Program memory for the fetch path: 1-cycle valid/ready fetch, plus a bootloader LOAD mode.
module program_memory_sync
   import program_memory_sync_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   program_memory_sync_if.slave   bus,
   output pm_state_e              dbg_state
);

   localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH+1)'(1);

   pm_state_e           state_d, state_q;
   logic                rsp_valid_d, rsp_valid_q;
   logic [ADDR_WIDTH:0] load_count_d, load_count_q;
   logic                req_ready;
   logic                rd_en;
   logic                wr_en;

   always_comb begin
      state_d      = state_q;
      rsp_valid_d  = rsp_valid_q;
      load_count_d = load_count_q;
      req_ready    = 1'b0;
      wr_en        = 1'b0;
      case (state_q)
         PM_IDLE: begin
            req_ready = ~rsp_valid_q | bus.rsp_ready;
            if (bus.load_start) begin
               state_d      = PM_LOAD;
               load_count_d = '0;
            end
         end
         PM_LOAD: begin
            // A write coinciding with load_done still lands and is counted.
            wr_en = bus.load_valid;
            if (bus.load_valid && (load_count_q != COUNT_MAX)) begin
               load_count_d = load_count_q + COUNT_ONE;
            end
            if (bus.load_done) begin
               state_d = PM_IDLE;
            end
         end
         default: state_d = PM_IDLE;
      endcase

      rd_en = bus.req_valid & req_ready;
      if (rd_en) begin
         rsp_valid_d = 1'b1;
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PM_IDLE;
         rsp_valid_q  <= 1'b0;
         load_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rsp_valid_q  <= rsp_valid_d;
         load_count_q <= load_count_d;
      end
   end

   program_memory_sync_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_storage (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (rd_en),
      .rd_addr (bus.req_addr),
      .rd_data (bus.rsp_instr),
      .wr_en   (wr_en),
      .wr_addr (bus.load_addr),
      .wr_data (bus.load_data)
   );

   assign bus.req_ready  = req_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.loading    = (state_q == PM_LOAD);
   assign bus.load_count = load_count_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_program_memory_sync.sv
// Directed bench for program_memory_sync: fetch latency/stall, LOAD mode, reset mid-LOAD.
module tb_program_memory_sync;
   import program_memory_sync_pkg::*;

   logic      clk;
   logic      rst_n;
   pm_state_e dbg_state;

   program_memory_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

   program_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   logic [15:0] mem_m [256];
   logic [15:0] exp_word;
   logic        acc_prev;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_prev = 1'b0;
      end else begin
         if (acc_prev) check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            end else begin
               exp_word = exp_q.pop_front();
               check("rsp_instr", 32'(bus.rsp_instr), 32'(exp_word));
            end
         end
         acc_prev = bus.req_valid && bus.req_ready;
         if (acc_prev) exp_q.push_back(mem_m[bus.req_addr]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [7:0] a);
      int budget = 0;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      @(negedge clk);
      while (!bus.req_ready && budget < 50) begin
         budget++;
         @(negedge clk);
      end
      check("req_accept", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int budget = 0;
      @(posedge clk); #1;
      while ((exp_q.size() != 0 || bus.rsp_valid) && budget < 50) begin
         budget++;
         @(posedge clk); #1;
      end
      check("drain_queue", 32'(exp_q.size()), 32'd0);
      check("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
      mem_m[0] = 16'hB203;
      mem_m[1] = 16'hB305;

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.rsp_ready  = 1'b1;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      bus.load_done  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_instr", 32'(bus.rsp_instr), 32'h0);
      check("rst_loading", 32'(bus.loading), 32'd0);
      check("rst_load_count", 32'(bus.load_count), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(PM_IDLE));
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // 1: default program words
      issue(8'd0);
      issue(8'd1);
      wait_drain();

      // 2: top address
      issue(8'd255);
      wait_drain();

      // 3: back-to-back stream
      for (int a = 0; a < 4; a++) issue(8'(a));
      wait_drain();

      // 4: stall holds the response and blocks requests
      issue(8'd1);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 8'd0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("stall_rsp_instr", 32'(bus.rsp_instr), 32'hB305);
         check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      next_cycle();
      bus.rsp_ready = 1'b1;
      issue(8'd0);
      wait_drain();

      // 5: LOAD mode
      bus.load_start = 1'b1;
      next_cycle();
      bus.load_start = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 8'd1;
      @(negedge clk);
      check("load_loading", 32'(bus.loading), 32'd1);
      check("load_req_ready", 32'(bus.req_ready), 32'd0);
      check("load_count_clr", 32'(bus.load_count), 32'd0);
      check("load_state", 32'(dbg_state), 32'(PM_LOAD));
      next_cycle();
      bus.load_valid = 1'b1; bus.load_addr = 8'd0; bus.load_data = 16'h1234;
      mem_m[0] = 16'h1234;
      next_cycle();
      bus.load_valid = 1'b0;
      bus.load_start = 1'b1;
      @(negedge clk);
      check("load_count_1", 32'(bus.load_count), 32'd1);
      next_cycle();
      bus.load_start = 1'b0;
      bus.load_valid = 1'b1; bus.load_addr = 8'd255; bus.load_data = 16'hFFFF;
      mem_m[255] = 16'hFFFF;
      next_cycle();
      bus.load_addr = 8'd1; bus.load_data = 16'hABCD; bus.load_done = 1'b1;
      mem_m[1] = 16'hABCD;
      @(negedge clk);
      check("load_last_loading", 32'(bus.loading), 32'd1);
      check("load_last_req_ready", 32'(bus.req_ready), 32'd0);
      next_cycle();
      bus.load_valid = 1'b0;
      bus.load_done  = 1'b0;
      @(negedge clk);
      check("done_loading", 32'(bus.loading), 32'd0);
      check("done_load_count", 32'(bus.load_count), 32'd3);
      check("done_req_ready", 32'(bus.req_ready), 32'd1);
      next_cycle();
      bus.req_valid = 1'b0;
      issue(8'd0);
      issue(8'd1);
      issue(8'd255);
      wait_drain();

      // load_valid/load_done in IDLE are ignored
      bus.load_valid = 1'b1; bus.load_addr = 8'd2; bus.load_data = 16'h5555;
      bus.load_done  = 1'b1;
      next_cycle();
      bus.load_valid = 1'b0;
      bus.load_done  = 1'b0;
      @(negedge clk);
      check("idle_load_count", 32'(bus.load_count), 32'd3);
      check("idle_loading", 32'(bus.loading), 32'd0);
      next_cycle();
      issue(8'd2);
      wait_drain();

      // 6: request + load_start together, then reset mid-LOAD with a pending response
      bus.rsp_ready  = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 8'd0;
      bus.load_start = 1'b1;
      next_cycle();
      bus.req_valid  = 1'b0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b1; bus.load_addr = 8'd3; bus.load_data = 16'h7777;
      mem_m[3] = 16'h7777;
      @(negedge clk);
      check("combo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("combo_rsp_instr", 32'(bus.rsp_instr), 32'h1234);
      check("combo_loading", 32'(bus.loading), 32'd1);
      next_cycle();
      bus.load_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_loading", 32'(bus.loading), 32'd0);
      check("mid_rst_rsp_instr", 32'(bus.rsp_instr), 32'h0);
      check("mid_rst_load_count", 32'(bus.load_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.rsp_ready = 1'b1;
      next_cycle();
      issue(8'd0);
      issue(8'd3);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
